// File: rtl/twiddle_streamer_if.sv
// Weight-load bus of the twiddle streamer: table write port, run control,
// and the valid-qualified weight word stream towards the FFT weight buffer.
interface twiddle_streamer_if #(
  parameter int NPOINT = 3,
  parameter int WIDTH  = 16
);
  logic              tbl_wr_en;
  logic [NPOINT-2:0] tbl_wr_addr;
  logic [WIDTH-1:0]  tbl_wr_real;
  logic [WIDTH-1:0]  tbl_wr_imag;
  logic              start;
  logic              stall;
  logic              busy;
  logic              done;
  logic              dout_weight_valid;
  logic [WIDTH-1:0]  dout_weight_real;
  logic [WIDTH-1:0]  dout_weight_imag;

  modport master (
    output tbl_wr_en, tbl_wr_addr, tbl_wr_real, tbl_wr_imag, start, stall,
    input  busy, done, dout_weight_valid, dout_weight_real, dout_weight_imag
  );

  modport slave (
    input  tbl_wr_en, tbl_wr_addr, tbl_wr_real, tbl_wr_imag, start, stall,
    output busy, done, dout_weight_valid, dout_weight_real, dout_weight_imag
  );
endinterface

// File: rtl/twiddle_streamer.sv
// Holds the N/2 distinct twiddle factors and, on start, streams the full
// per-stage/per-butterfly weight sequence, last slot first.
module twiddle_streamer #(
  parameter int NPOINT = 3,
  parameter int WIDTH  = 16
) (
  input  logic                clk,
  input  logic                rst,
  twiddle_streamer_if.slave   bus
);
  localparam int AW    = NPOINT - 1;
  localparam int HALF  = 1 << AW;
  localparam int TOTAL = NPOINT * HALF;
  localparam int CW    = $clog2(TOTAL);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic             busy, busy_d;
  logic             done, done_d;
  logic             valid, valid_d;
  logic [WIDTH-1:0] dout_real, dout_real_d;
  logic [WIDTH-1:0] dout_imag, dout_imag_d;

  // NOTE: the table is cleared by rst, so it is built from resettable
  // registers rather than a RAM macro (RAMs cannot be reset in one cycle).
  logic [WIDTH-1:0] tbl_real [HALF];
  logic [WIDTH-1:0] tbl_imag [HALF];

  logic [CW-1:0] stage;
  logic [AW-1:0] bfly, mask, k;

  // Slot cnt = stage*HALF + butterfly; k = (j mod 2^s) << (NPOINT-1-s).
  always_comb begin
    stage = cnt >> AW;
    bfly  = cnt[AW-1:0];
    mask  = AW'((32'd1 << stage) - 32'd1);
    k     = (bfly & mask) << (AW - int'(stage));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < HALF; i++) begin
        tbl_real[i] <= '0;
        tbl_imag[i] <= '0;
      end
    end else if (bus.tbl_wr_en && state == IDLE) begin
      tbl_real[bus.tbl_wr_addr] <= bus.tbl_wr_real;
      tbl_imag[bus.tbl_wr_addr] <= bus.tbl_wr_imag;
    end
  end

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    valid_d     = 1'b0;
    dout_real_d = dout_real;
    dout_imag_d = dout_imag;
    unique case (state)
      IDLE: begin
        // The done-pulse cycle is still part of the finished run, so a new
        // start is only taken from the cycle after it.
        if (bus.start && !done) begin
          state_d = RUN;
          cnt_d   = CW'(TOTAL - 1);
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        busy_d = 1'b1;
        if (!bus.stall) begin
          valid_d     = 1'b1;
          dout_real_d = tbl_real[k];
          dout_imag_d = tbl_imag[k];
          if (cnt == '0) state_d = DONE;
          else           cnt_d   = cnt - 1'b1;
        end
      end
      DONE: begin
        busy_d  = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      valid     <= 1'b0;
      dout_real <= '0;
      dout_imag <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      busy      <= busy_d;
      done      <= done_d;
      valid     <= valid_d;
      dout_real <= dout_real_d;
      dout_imag <= dout_imag_d;
    end
  end

  assign bus.busy              = busy;
  assign bus.done              = done;
  assign bus.dout_weight_valid = valid;
  assign bus.dout_weight_real  = dout_real;
  assign bus.dout_weight_imag  = dout_imag;
endmodule

// File: doc/twiddle_streamer.md
# twiddle_streamer

Source side of the serial twiddle-weight load path: holds the N/2 distinct twiddle factors W_N^k (N = 2^NPOINT) in a small register table. On `start` it emits the full per-stage, per-butterfly weight sequence, one word per cycle, on a valid-qualified bus. Emission order matches a left-shifting weight buffer, so after the last word the buffer slot at bits [WIDTH-1:0] holds stage 0 / butterfly 0. The block sits between configuration (table load) and the fully parallel FFT's weight buffer.

## Interface
- NPOINT, 3, log2 of FFT points; legal range 2 or more
- WIDTH, 16, bits per real/imag component
- Derived constants: HALF = 2^(NPOINT-1); TOTAL = NPOINT*HALF
- clk  in  1  clock; all logic rising-edge
- rst  in  1  reset, asynchronous, active-high
- tbl_wr_en  in  1  table write strobe
- tbl_wr_addr  in  NPOINT-1  table index k (0..HALF-1)
- tbl_wr_real  in  WIDTH  real part of W_N^k
- tbl_wr_imag  in  WIDTH  imaginary part of W_N^k
- start  in  1  begin emission; sampled only in IDLE
- stall  in  1  suppresses emission in the current RUN cycle
- busy  out  1  high from the cycle after start is accepted through the done cycle, inclusive
- done  out  1  one-cycle pulse after the last word
- dout_weight_valid  out  1  word qualifier
- dout_weight_real  out  WIDTH  emitted real part
- dout_weight_imag  out  WIDTH  emitted imaginary part

## Operation
- Table: HALF entries of real/imag registers, cleared to 0 by rst.
  - Write on a clk edge when tbl_wr_en=1 and state is IDLE.
  - Writes in RUN or DONE are ignored.
- Slot numbering: i = s*HALF + j, where s is the stage (0..NPOINT-1) and j is the butterfly (0..HALF-1).
- Twiddle index for slot i: k(s,j) = (j mod 2^s) * 2^(NPOINT-1-s). Stage 0 is therefore always k=0.
- Emission order: slot TOTAL-1 first, down to slot 0 last.
- FSM:
  - IDLE: start=1 goes to RUN, with slot counter cnt = TOTAL-1.
  - RUN, stall=0: register table[k(cnt)] onto dout, set valid=1, decrement cnt. If cnt was 0, go to DONE.
  - RUN, stall=1: valid=0, dout data holds, cnt holds.
  - DONE: done=1 and valid=0 for exactly one cycle, then go to IDLE.
- start outside IDLE is ignored. stall outside RUN is ignored.
- No arithmetic on data; words pass unmodified. Only the index computation uses shifts and masks.

## Timing
- Reset values: busy=0, done=0, dout_weight_valid=0, dout_weight_real=0, dout_weight_imag=0, state IDLE, cnt=0, table all 0.
- All outputs are registered.
- Edge E0 samples start=1 in IDLE; busy=1 from after E0.
- First valid word appears after E1, given stall=0.
- With no stalls, valid is high for TOTAL consecutive cycles (after E1 .. E_TOTAL).
- done=1 in the cycle after E_TOTAL+1; busy falls together with done.
- Each stalled cycle adds exactly one cycle to the above.
- start can be re-accepted the cycle done is high? No: it is accepted in the cycle after done, once back in IDLE.
- A table write in the same cycle as start (IDLE) is applied. The first word read comes from E1, so it sees the new value.
- rst asserted mid-RUN clears all state immediately, asynchronously. No done pulse follows. Table contents are lost.

## Test plan
- Reset/idle: assert rst with random inputs -> all outputs 0. Deassert with no start -> outputs stay 0.
- Basic stream, NPOINT=3: load real=10+k, imag=20+k for k=0..3, then pulse start -> 12 consecutive valid words.
  - real: 13,12,11,10,12,10,12,10,10,10,10,10
  - imag: real+10 for each word
  - done pulses one cycle after the last valid word; busy spans 14 cycles.
- Stall: same setup, stall=1 on RUN cycles 3 and 7 -> same 12 values, gaps at those cycles, done delayed by 2 cycles.
- Ignored inputs:
  - start pulsed again mid-RUN -> no restart.
  - tbl_wr_en with k=3, real=99 mid-RUN -> ignored; a following run still emits 13 first.
- Reset mid-run: rst after 5 valid words -> valid drops immediately, no done. Next start without reload -> 12 words, all 0.
- NPOINT=4 sweep: load real=k (k=0..7) -> 32 words.
  - Stage 3 words, in emission order: 7..0.
  - Stage 2 words: 6,4,2,0,6,4,2,0.
  - Stage 1 words: 4,0 repeated.
  - Stage 0 words: all 0.
